// File: rtl/glitch_cmd_encoder.sv
// Serializes one glitcher command (opcode, 32-bit value, passthrough payload) into the byte
// stream the FPGA-side command parser expects, feeding a uart_tx-style byte sink.
module glitch_cmd_encoder #(
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned PAY_TIMEOUT = 0,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_value,
  input  logic [7:0]  cmd_len,
  input  logic [7:0]  pay_data,
  input  logic        pay_valid,
  output logic        pay_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic        padded
);

  typedef enum logic [2:0] {StIdle, StOpcode, StLen, StPayload, StValue, StGap} state_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [31:0] value_q;
  logic [7:0]  len_q;
  logic [7:0]  rem_q;
  logic [1:0]  idx_q;
  logic [31:0] gap_cnt_q;
  logic [31:0] to_cnt_q;
  logic        pad_q;
  logic        cmd_ready_q;
  logic        cmd_done_q;
  logic        cmd_err_q;
  logic        padded_q;

  logic        xfer;
  logic        frame_end;
  logic        req_bad;

  assign cmd_ready = cmd_ready_q;
  assign cmd_done  = cmd_done_q;
  assign cmd_err   = cmd_err_q;
  assign padded    = padded_q;

  // Byte outputs decode from held registers, so they stay put while the sink stalls.
  always_comb begin
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    pay_ready = 1'b0;
    case (state_q)
      StOpcode: begin
        tx_data  = {5'b00000, op_q};
        tx_valid = 1'b1;
      end
      StLen: begin
        tx_data  = len_q;
        tx_valid = 1'b1;
      end
      StPayload: begin
        if (pad_q) begin
          tx_data  = PAD_BYTE;
          tx_valid = 1'b1;
        end else begin
          tx_data   = pay_data;
          tx_valid  = pay_valid;
          pay_ready = pay_valid & tx_ready;
        end
      end
      StValue: begin
        tx_data  = value_q[{idx_q, 3'b000} +: 8];
        tx_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign xfer = tx_valid & tx_ready;

  always_comb begin
    frame_end = 1'b0;
    if (xfer) begin
      case (state_q)
        StOpcode:  frame_end = (op_q == 3'd1) || (op_q == 3'd4);
        StPayload: frame_end = (rem_q == 8'd1);
        StValue:   frame_end = (idx_q == 2'd3);
        default:   frame_end = 1'b0;
      endcase
    end
  end

  // A zero-length passthrough would make the parser swallow 256 bytes, so it is refused.
  assign req_bad = (cmd_op > 3'd4) || ((cmd_op == 3'd0) && (cmd_len == 8'd0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      op_q        <= 3'd0;
      value_q     <= 32'd0;
      len_q       <= 8'd0;
      rem_q       <= 8'd0;
      idx_q       <= 2'd0;
      gap_cnt_q   <= 32'd0;
      to_cnt_q    <= 32'd0;
      pad_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      cmd_done_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      padded_q    <= 1'b0;
    end else begin
      cmd_done_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      padded_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_ready_q && cmd_valid) begin
            cmd_ready_q <= 1'b0;
            op_q        <= cmd_op;
            value_q     <= cmd_value;
            len_q       <= cmd_len;
            pad_q       <= 1'b0;
            if (req_bad) begin
              cmd_err_q <= 1'b1;
            end else begin
              state_q <= StOpcode;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        StOpcode: begin
          if (xfer) begin
            if (op_q == 3'd0) begin
              state_q <= StLen;
            end else if ((op_q == 3'd2) || (op_q == 3'd3)) begin
              state_q <= StValue;
              idx_q   <= 2'd0;
            end
          end
        end
        StLen: begin
          if (xfer) begin
            state_q  <= StPayload;
            rem_q    <= len_q;
            to_cnt_q <= 32'd0;
          end
        end
        StPayload: begin
          if (xfer) begin
            rem_q <= rem_q - 8'd1;
          end
          if ((PAY_TIMEOUT != 0) && !pad_q) begin
            if (pay_valid) begin
              to_cnt_q <= 32'd0;
            end else if (to_cnt_q == PAY_TIMEOUT - 1) begin
              pad_q <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + 32'd1;
            end
          end
        end
        StValue: begin
          if (xfer) begin
            idx_q <= idx_q + 2'd1;
          end
        end
        StGap: begin
          if (gap_cnt_q == GAP_CYCLES - 1) begin
            cmd_done_q <= 1'b1;
            padded_q   <= pad_q;
            state_q    <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
      // Last byte of any frame type overrides the per-state transition above.
      if (frame_end) begin
        gap_cnt_q <= 32'd0;
        if (GAP_CYCLES == 0) begin
          cmd_done_q <= 1'b1;
          padded_q   <= pad_q;
          state_q    <= StIdle;
        end else begin
          state_q <= StGap;
        end
      end
    end
  end

endmodule
